// File: rtl/writeback_stage.sv
// Final pipeline stage: selects writeback data (ALU, memory or input FIFO) and
// registers the register-file write, output-port write and PC redirect strobes.
module writeback_stage #(
  parameter int DATA_WIDTH = 16,
  parameter int IN_DEPTH   = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  input_IN,
  input  logic                  wren_IN,
  input  logic [2:0]            writeAd_IN,
  input  logic                  ADR_MUX_IN,
  input  logic                  write_IN,
  input  logic                  PC_load_IN,
  input  logic [DATA_WIDTH-1:0] alu_result_IN,
  input  logic [DATA_WIDTH-1:0] mem_data_IN,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  stall_OUT,
  output logic                  regWrite_OUT,
  output logic [2:0]            regAd_OUT,
  output logic [DATA_WIDTH-1:0] regData_OUT,
  output logic                  out_valid_OUT,
  output logic [DATA_WIDTH-1:0] out_data_OUT,
  output logic                  pc_load_OUT,
  output logic [DATA_WIDTH-1:0] pc_target_OUT,
  output logic [15:0]           retire_count_OUT
);

  localparam int PTR_W = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
  localparam int CNT_W = $clog2(IN_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(IN_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(IN_DEPTH - 1);

  logic [DATA_WIDTH-1:0] fifo_mem [IN_DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      occ;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  push;
  logic                  pop;

  logic                  vld_p0;
  logic                  active_p0;
  logic [DATA_WIDTH-1:0] sel_data_p0;

  function automatic logic [DATA_WIDTH-1:0] select_data(
    input logic                  from_fifo,
    input logic                  from_mem,
    input logic [DATA_WIDTH-1:0] head,
    input logic [DATA_WIDTH-1:0] mem,
    input logic [DATA_WIDTH-1:0] alu
  );
    if (from_fifo) return head;
    else if (from_mem) return mem;
    else return alu;
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // ---- stage p0: FIFO status, stall and data select (combinational) ----
  assign fifo_empty = (occ == '0);
  assign fifo_full  = (occ == FULL_CNT);
  assign in_ready   = !fifo_full;
  assign push       = in_valid && !fifo_full;

  // A word pushed into an empty FIFO is only visible next cycle: no bypass.
  assign stall_OUT   = input_IN && fifo_empty;
  assign vld_p0      = !stall_OUT;
  assign pop         = vld_p0 && input_IN;
  assign active_p0   = wren_IN || write_IN || PC_load_IN;
  assign sel_data_p0 = select_data(input_IN, ADR_MUX_IN, fifo_mem[rd_ptr],
                                   mem_data_IN, alu_result_IN);

  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   occ <= occ + CNT_W'(1);
        2'b01:   occ <= occ - CNT_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // ---- stage p1: registered writeback strobes, data and retire counter ----
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      regWrite_OUT  <= 1'b0;
      out_valid_OUT <= 1'b0;
      pc_load_OUT   <= 1'b0;
    end else if (vld_p0) begin
      regWrite_OUT  <= wren_IN;
      out_valid_OUT <= write_IN;
      pc_load_OUT   <= PC_load_IN;
    end else begin
      regWrite_OUT  <= 1'b0;
      out_valid_OUT <= 1'b0;
      pc_load_OUT   <= 1'b0;
    end
  end

  // Data outputs hold across stalls so the last written values stay observable.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      regAd_OUT     <= '0;
      regData_OUT   <= '0;
      out_data_OUT  <= '0;
      pc_target_OUT <= '0;
    end else if (vld_p0) begin
      regAd_OUT     <= writeAd_IN;
      regData_OUT   <= sel_data_p0;
      out_data_OUT  <= sel_data_p0;
      pc_target_OUT <= sel_data_p0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) retire_count_OUT <= '0;
    else if (vld_p0 && active_p0) retire_count_OUT <= retire_count_OUT + 16'd1;
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed and randomized bench for writeback_stage, checked against a
// queue-based reference model of the stage behaviour.
module tb_writeback_stage;
  localparam int DW    = 16;
  localparam int DEPTH = 2;

  logic          CLK = 1'b0;
  logic          RST;
  logic          input_IN, wren_IN, ADR_MUX_IN, write_IN, PC_load_IN;
  logic [2:0]    writeAd_IN;
  logic [DW-1:0] alu_result_IN, mem_data_IN, in_data;
  logic          in_valid;
  logic          in_ready, stall_OUT, regWrite_OUT, out_valid_OUT, pc_load_OUT;
  logic [2:0]    regAd_OUT;
  logic [DW-1:0] regData_OUT, out_data_OUT, pc_target_OUT;
  logic [15:0]   retire_count_OUT;

  always #5 CLK = ~CLK;

  writeback_stage #(.DATA_WIDTH(DW), .IN_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .input_IN(input_IN), .wren_IN(wren_IN),
    .writeAd_IN(writeAd_IN), .ADR_MUX_IN(ADR_MUX_IN), .write_IN(write_IN),
    .PC_load_IN(PC_load_IN), .alu_result_IN(alu_result_IN),
    .mem_data_IN(mem_data_IN), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .stall_OUT(stall_OUT), .regWrite_OUT(regWrite_OUT),
    .regAd_OUT(regAd_OUT), .regData_OUT(regData_OUT),
    .out_valid_OUT(out_valid_OUT), .out_data_OUT(out_data_OUT),
    .pc_load_OUT(pc_load_OUT), .pc_target_OUT(pc_target_OUT),
    .retire_count_OUT(retire_count_OUT)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [DW-1:0] q[$];
  logic          m_regw, m_outv, m_pcl;
  logic [2:0]    m_regad;
  logic [DW-1:0] m_regdata, m_outd, m_pct;
  int            m_cnt;
  logic          m_last_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_regw = 0; m_outv = 0; m_pcl = 0; m_regad = '0;
    m_regdata = '0; m_outd = '0; m_pct = '0; m_cnt = 0; m_last_stall = 0;
  endtask

  task automatic set_op(input logic inp, input logic wr, input logic [2:0] ad,
                        input logic mux, input logic wo, input logic pcl,
                        input logic [DW-1:0] alu, input logic [DW-1:0] mem);
    input_IN = inp; wren_IN = wr; writeAd_IN = ad; ADR_MUX_IN = mux;
    write_IN = wo; PC_load_IN = pcl; alu_result_IN = alu; mem_data_IN = mem;
  endtask

  task automatic set_in(input logic v, input logic [DW-1:0] d);
    in_valid = v; in_data = d;
  endtask

  task automatic check_outs();
    chk("regWrite", regWrite_OUT, m_regw);
    chk("regAd", regAd_OUT, m_regad);
    chk("regData", regData_OUT, m_regdata);
    chk("out_valid", out_valid_OUT, m_outv);
    chk("out_data", out_data_OUT, m_outd);
    chk("pc_load", pc_load_OUT, m_pcl);
    chk("pc_target", pc_target_OUT, m_pct);
    chk("retire_count", retire_count_OUT, 32'(m_cnt));
  endtask

  // One clock cycle: check combinational outputs, advance the model, check registered outputs.
  task automatic tick();
    logic          stall_e, ready_e, push;
    logic [DW-1:0] sel;
    #1;
    stall_e = input_IN && (q.size() == 0);
    ready_e = (q.size() < DEPTH);
    chk("stall", stall_OUT, stall_e);
    chk("in_ready", in_ready, ready_e);
    push = in_valid && ready_e;
    if (!stall_e) begin
      sel = input_IN ? q[0] : (ADR_MUX_IN ? mem_data_IN : alu_result_IN);
      m_regw = wren_IN; m_regad = writeAd_IN; m_regdata = sel;
      m_outv = write_IN; m_outd = sel;
      m_pcl = PC_load_IN; m_pct = sel;
      if (input_IN) void'(q.pop_front());
      if (wren_IN || write_IN || PC_load_IN) m_cnt = (m_cnt + 1) % 65536;
    end else begin
      m_regw = 0; m_outv = 0; m_pcl = 0;
    end
    if (push) q.push_back(in_data);
    m_last_stall = stall_e;
    @(posedge CLK);
    #1;
    check_outs();
  endtask

  // Asynchronous reset pulse from a point between edges, then resync to posedge+1.
  task automatic do_reset();
    RST = 1'b1;
    #1;
    model_reset();
    check_outs();
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_stall", stall_OUT, input_IN);
    set_op(0, 0, 0, 0, 0, 0, '0, '0);
    set_in(0, '0);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    check_outs();
  endtask

  initial begin
    logic          inp, wr, mux, wo, pcl;
    logic [2:0]    ad;
    int            cnt_before;
    RST = 1'b1;
    set_op(0, 0, 0, 0, 0, 0, '0, '0);
    set_in(0, '0);
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    do_reset();

    // ALU writeback
    set_op(0, 1, 3'd5, 0, 0, 0, 16'h1234, 16'h9999);
    tick();
    chk("alu_regWrite", regWrite_OUT, 1'b1);
    chk("alu_regAd", regAd_OUT, 3'd5);
    chk("alu_regData", regData_OUT, 16'h1234);
    chk("alu_count", retire_count_OUT, 16'd1);
    set_op(0, 0, 0, 0, 0, 0, '0, '0);
    tick();

    // Input op stalls on empty FIFO, then accepted the cycle after the push
    set_op(1, 1, 3'd3, 0, 0, 0, 16'h1111, 16'h2222);
    tick();
    chk("stall_strobe", regWrite_OUT, 1'b0);
    set_in(1, 16'hBEEF);
    tick();
    chk("stall_same_cycle_push", regWrite_OUT, 1'b0);
    set_in(0, '0);
    tick();
    chk("in_regData", regData_OUT, 16'hBEEF);
    chk("in_regAd", regAd_OUT, 3'd3);
    chk("in_regWrite", regWrite_OUT, 1'b1);

    // Fill FIFO, reject third word, drain in order
    set_op(0, 0, 0, 0, 0, 0, '0, '0);
    set_in(1, 16'h0001); tick();
    set_in(1, 16'h0002); tick();
    set_in(1, 16'h0003); tick();
    chk("full_in_ready", in_ready, 1'b0);
    set_in(0, '0);
    set_op(1, 1, 3'd1, 0, 0, 0, '0, '0);
    tick();
    chk("drain1", regData_OUT, 16'h0001);
    tick();
    chk("drain2", regData_OUT, 16'h0002);
    set_op(0, 0, 0, 0, 0, 0, '0, '0);
    tick();

    // Simultaneous push and pop with one entry held
    set_in(1, 16'h0005); tick();
    set_op(1, 1, 3'd2, 0, 0, 0, '0, '0);
    set_in(1, 16'h000A); tick();
    chk("pp_first", regData_OUT, 16'h0005);
    set_in(0, '0);
    tick();
    chk("pp_second", regData_OUT, 16'h000A);

    // PC load, output port, bubble
    set_op(0, 0, 0, 1, 0, 1, 16'h0011, 16'h0040);
    tick();
    chk("pc_load", pc_load_OUT, 1'b1);
    chk("pc_target", pc_target_OUT, 16'h0040);
    set_op(0, 0, 0, 0, 1, 0, 16'h0077, 16'h0000);
    tick();
    chk("pc_one_cycle", pc_load_OUT, 1'b0);
    chk("out_valid", out_valid_OUT, 1'b1);
    chk("out_data", out_data_OUT, 16'h0077);
    cnt_before = 32'(retire_count_OUT);
    set_op(0, 0, 0, 0, 0, 0, 16'h0, 16'h0);
    tick();
    chk("bubble_count", retire_count_OUT, 32'(cnt_before));
    chk("bubble_out_valid", out_valid_OUT, 1'b0);

    // Randomized traffic; a stalled op is held until accepted
    for (int i = 0; i < 400; i++) begin
      if (!m_last_stall) begin
        inp = 1'($urandom_range(0, 3) == 0);
        wr  = 1'($urandom); wo = 1'($urandom); pcl = 1'($urandom_range(0, 3) == 0);
        mux = 1'($urandom); ad = 3'($urandom);
        if (inp && !(wr || wo || pcl)) wr = 1'b1;
        set_op(inp, wr, ad, mux, wo, pcl, 16'($urandom), 16'($urandom));
      end
      set_in(1'($urandom), 16'($urandom));
      tick();
    end

    // Retire counter wrap
    set_in(0, '0);
    do_reset();
    set_op(0, 1, 3'd7, 0, 0, 0, 16'h0055, 16'h0);
    repeat (65535) @(posedge CLK);
    #1;
    m_cnt = 65535; m_regw = 1; m_regad = 3'd7; m_regdata = 16'h0055;
    m_outd = 16'h0055; m_pct = 16'h0055; m_outv = 0; m_pcl = 0;
    check_outs();
    tick();
    chk("wrap_count", retire_count_OUT, 16'h0000);

    // Reset with FIFO full and an input op pending
    set_op(0, 0, 0, 0, 0, 0, '0, '0);
    set_in(1, 16'h00C1); tick();
    set_in(1, 16'h00C2); tick();
    set_in(1, 16'h00C3);
    set_op(1, 1, 3'd4, 0, 0, 0, '0, '0);
    #1;
    chk("pre_rst_in_ready", in_ready, 1'b0);
    chk("pre_rst_stall", stall_OUT, 1'b0);
    do_reset();
    set_op(1, 1, 3'd4, 0, 0, 0, '0, '0);
    tick();
    chk("post_rst_discard", regWrite_OUT, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
